// File: rtl/mod_hi_speed_protocol_encoder.sv
// mod_hi_speed_protocol_encoder: transmit side of the high-speed serial link.
// Builds one frame per START (marker, flag, 16-bit count, N RAM bytes, CRC16) and
// serializes it as RS-485 characters (start, 8 data LSB first, even parity, stop),
// each bit lasting four CLK_EN_RS pulses, followed by an idle-high end-of-message gap.
// Ports: CLK, RESET (async, active-low), CLK_EN_RS (4x bit-rate enable),
//        START/TX_FLAG/TX_BYTE_NUMBER (frame request), TX_RAM_REQ_RD/TX_RAM_RDY_RD/
//        TX_RAM_ADDR_OUT/TX_RAM_DATA_IN (payload read port), OUT (serial line),
//        BUSY (frame in progress), TX_END_MESSAGE (one-CLK end-of-frame pulse).

// mod_hi_speed_protocol_encoder_crc16: CRC16 (poly 0x1021, init 0xFFFF, MSB first), one byte per clk_en.
// Ports: clk, rst_n, clr (forces init value), clk_en (absorb d), d (byte), crc (register value).
module mod_hi_speed_protocol_encoder_crc16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        clk_en,
    input  logic [7:0]  d,
    output logic [15:0] crc
);
    logic [15:0] crc_q, crc_d, nxt;
    always_comb begin
        nxt = crc_q ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            nxt = nxt[15] ? {nxt[14:0], 1'b0} ^ 16'h1021 : {nxt[14:0], 1'b0};
        crc_d = clr ? 16'hFFFF : clk_en ? nxt : crc_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= 16'hFFFF;
        else        crc_q <= crc_d;
    end
    assign crc = crc_q;
endmodule

module mod_hi_speed_protocol_encoder #(
    parameter logic [7:0] MARKER_BYTE = 8'hA5,
    parameter int         GAP_BITS    = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLK_EN_RS,
    input  logic        START,
    input  logic [7:0]  TX_FLAG,
    input  logic [15:0] TX_BYTE_NUMBER,
    output logic        TX_RAM_REQ_RD,
    input  logic        TX_RAM_RDY_RD,
    output logic [15:0] TX_RAM_ADDR_OUT,
    input  logic [7:0]  TX_RAM_DATA_IN,
    output logic        OUT,
    output logic        BUSY,
    output logic        TX_END_MESSAGE
);
    localparam int GAP_W = $clog2(GAP_BITS * 4);
    typedef enum logic [2:0] {IDLE, HDR, RD_REQ, DATA, CRC_LATCH, CRC_TX, GAP, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] flag_q, flag_d, pf_q, pf_d, ld_byte, hdr_byte;
    logic [15:0] num_q, num_d, addr_q, addr_d, crc_out_q, crc_out_d, crc;
    logic [1:0] idx_q, idx_d, phase_q, phase_d;
    logic [3:0] cnt_q, cnt_d;
    logic [10:0] sh_q, sh_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic act_q, act_d, req_q, req_d, load, crc_en, bit_end, slot;
    mod_hi_speed_protocol_encoder_crc16 u_crc (
        .clk(CLK), .rst_n(RESET), .clr(state_q == IDLE), .clk_en(crc_en), .d(ld_byte), .crc(crc)
    );
    always_comb begin
        state_d = state_q;
        flag_d = flag_q;
        num_d = num_q;
        pf_d = pf_q;
        addr_d = addr_q;
        crc_out_d = crc_out_q;
        idx_d = idx_q;
        req_d = req_q;
        gap_d = gap_q;
        load = 1'b0;
        crc_en = 1'b0;
        hdr_byte = idx_q == 2'd0 ? MARKER_BYTE : idx_q == 2'd1 ? flag_q : idx_q == 2'd2 ? num_q[15:8] : num_q[7:0];
        ld_byte = state_q == HDR ? hdr_byte : state_q == DATA ? pf_q : idx_q[0] ? crc_out_q[7:0] : crc_out_q[15:8];
        bit_end = CLK_EN_RS && act_q && phase_q == 2'd3;
        // a new character may start when the line is idle or on the pulse that ends a stop bit
        slot = CLK_EN_RS && (!act_q || (bit_end && cnt_q == 4'd0));
        case (state_q)
            IDLE: if (START) begin
                flag_d = TX_FLAG;
                num_d = TX_BYTE_NUMBER;
                idx_d = 2'd0;
                state_d = HDR;
            end
            HDR: if (slot) begin
                load = 1'b1;
                crc_en = 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = num_q == 16'd0 ? CRC_LATCH : RD_REQ;
                    req_d = num_q != 16'd0;
                end
            end
            RD_REQ: if (TX_RAM_RDY_RD) begin
                pf_d = TX_RAM_DATA_IN;
                req_d = 1'b0;
                addr_d = addr_q + 16'd1;
                state_d = DATA;
            end
            // addr_q already counts the byte held in the prefetch register
            DATA: if (slot) begin
                load = 1'b1;
                crc_en = 1'b1;
                state_d = addr_q == num_q ? CRC_LATCH : RD_REQ;
                req_d = addr_q != num_q;
            end
            CRC_LATCH: begin
                crc_out_d = crc;
                idx_d = 2'd0;
                state_d = CRC_TX;
            end
            CRC_TX: if (slot) begin
                load = 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q[0]) begin
                    state_d = GAP;
                    gap_d = '0;
                end
            end
            // gap counting starts only once the final stop bit has ended
            GAP: if (CLK_EN_RS && !act_q) begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_W'(GAP_BITS * 4 - 1)) state_d = DONE;
            end
            DONE: begin
                addr_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        phase_d = (CLK_EN_RS && act_q) ? phase_q + 2'd1 : phase_q;
        sh_d = bit_end ? {1'b1, sh_q[10:1]} : sh_q;
        cnt_d = bit_end ? cnt_q - 4'd1 : cnt_q;
        act_d = (bit_end && cnt_q == 4'd0) ? 1'b0 : act_q;
        if (load) begin
            sh_d = {1'b1, ^ld_byte, ld_byte, 1'b0};
            cnt_d = 4'd10;
            phase_d = 2'd0;
            act_d = 1'b1;
        end
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            flag_q <= '0;
            num_q <= '0;
            pf_q <= '0;
            addr_q <= '0;
            crc_out_q <= '0;
            idx_q <= '0;
            req_q <= 1'b0;
            gap_q <= '0;
            phase_q <= '0;
            sh_q <= '1;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q <= flag_d;
            num_q <= num_d;
            pf_q <= pf_d;
            addr_q <= addr_d;
            crc_out_q <= crc_out_d;
            idx_q <= idx_d;
            req_q <= req_d;
            gap_q <= gap_d;
            phase_q <= phase_d;
            sh_q <= sh_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end
    assign OUT = act_q ? sh_q[0] : 1'b1;
    assign BUSY = state_q != IDLE && state_q != DONE;
    assign TX_END_MESSAGE = state_q == DONE;
    assign TX_RAM_REQ_RD = req_q;
    assign TX_RAM_ADDR_OUT = addr_q;
endmodule

// File: tb/tb_mod_hi_speed_protocol_encoder.sv
// tb_mod_hi_speed_protocol_encoder: frame-level checks of the encoder against a byte/line reference model.
module tb_mod_hi_speed_protocol_encoder;
    logic CLK = 1'b0, RESET = 1'b0, CLK_EN_RS = 1'b0, START = 1'b0, TX_RAM_RDY_RD = 1'b0;
    logic [7:0] TX_FLAG = '0, TX_RAM_DATA_IN = '0;
    logic [15:0] TX_BYTE_NUMBER = '0;
    logic TX_RAM_REQ_RD, OUT, BUSY, TX_END_MESSAGE;
    logic [15:0] TX_RAM_ADDR_OUT;
    int tests = 0, fails = 0;
    logic [7:0] mem [256];
    int ram_delay = 1, req_age = 0, en_cnt = 0;
    int addrs[$], idles[$];
    logic [7:0] exp_q[$], got[$];
    logic smp[$];
    int bad, trail, ends, reqc;

    always #5 CLK = ~CLK;

    mod_hi_speed_protocol_encoder dut (
        .CLK(CLK), .RESET(RESET), .CLK_EN_RS(CLK_EN_RS), .START(START),
        .TX_FLAG(TX_FLAG), .TX_BYTE_NUMBER(TX_BYTE_NUMBER),
        .TX_RAM_REQ_RD(TX_RAM_REQ_RD), .TX_RAM_RDY_RD(TX_RAM_RDY_RD),
        .TX_RAM_ADDR_OUT(TX_RAM_ADDR_OUT), .TX_RAM_DATA_IN(TX_RAM_DATA_IN),
        .OUT(OUT), .BUSY(BUSY), .TX_END_MESSAGE(TX_END_MESSAGE)
    );

    // enable pulse every second CLK
    initial forever begin
        @(negedge CLK);
        en_cnt++;
        CLK_EN_RS = (en_cnt % 2) == 0;
    end

    // RAM: answers a request ram_delay cycles after it rises, one-cycle RDY
    initial forever begin
        @(negedge CLK);
        if (TX_RAM_RDY_RD) begin
            TX_RAM_RDY_RD = 1'b0;
            req_age = 0;
        end else if (TX_RAM_REQ_RD) begin
            req_age++;
            if (req_age >= ram_delay) begin
                TX_RAM_RDY_RD = 1'b1;
                TX_RAM_DATA_IN = mem[TX_RAM_ADDR_OUT[7:0]];
                addrs.push_back(int'(TX_RAM_ADDR_OUT));
            end
        end else req_age = 0;
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        tests++;
        assert (got_v === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic build_exp(input logic [7:0] flag, input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(flag);
        exp_q.push_back(8'(n >> 8));
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
        foreach (exp_q[k])
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ exp_q[k][b];
                c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
    endtask

    // turns per-enable-pulse line samples into characters, idle runs and trailing idle
    task automatic decode();
        int j, run;
        bit first;
        logic [10:0] ch;
        got.delete();
        idles.delete();
        bad = 0;
        run = 0;
        first = 1;
        j = 0;
        while (j < smp.size()) begin
            if (smp[j] == 1'b1) begin
                run++;
                j++;
            end else begin
                if (j + 44 > smp.size()) begin
                    bad++;
                    break;
                end
                for (int b = 0; b < 11; b++) begin
                    ch[b] = smp[j + 4 * b];
                    for (int q = 1; q < 4; q++) if (smp[j + 4 * b + q] !== ch[b]) bad++;
                end
                if (ch[9] !== ^ch[8:1] || ch[10] !== 1'b1) bad++;
                if (!first) idles.push_back(run);
                first = 0;
                run = 0;
                got.push_back(ch[8:1]);
                j += 44;
            end
        end
        trail = run;
    endtask

    task automatic run_frame(input logic [7:0] flag, input int n, input int delay, input int again,
                             input bit fast, input string tag);
        int cyc;
        bit done;
        ram_delay = delay;
        addrs.delete();
        smp.delete();
        build_exp(flag, n);
        @(posedge CLK); #1;
        TX_FLAG = flag;
        TX_BYTE_NUMBER = 16'(n);
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        TX_FLAG = 8'($urandom);
        TX_BYTE_NUMBER = 16'($urandom);
        chk({tag, " busy"}, 32'(BUSY), 1);
        cyc = 0;
        done = 0;
        ends = 0;
        reqc = 0;
        while (!done && cyc < 20000) begin
            @(posedge CLK); #1;
            cyc++;
            START = (cyc == again);
            if (TX_RAM_REQ_RD) reqc++;
            if (CLK_EN_RS) smp.push_back(OUT);
            if (TX_END_MESSAGE) begin
                done = 1;
                ends++;
                chk({tag, " busy at end"}, 32'(BUSY), 0);
            end
        end
        chk({tag, " end seen"}, 32'(done), 1);
        START = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (TX_END_MESSAGE) ends++;
        end
        chk({tag, " busy after"}, 32'(BUSY), 0);
        chk({tag, " end pulses"}, 32'(ends), 1);
        decode();
        chk({tag, " bad chars"}, 32'(bad), 0);
        chk({tag, " char count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        chk({tag, " gap pulses"}, 32'(trail - 1), 64);
        chk({tag, " req used"}, 32'(reqc != 0), 32'(n != 0));
        chk({tag, " reads"}, 32'(addrs.size()), 32'(n));
        for (int i = 0; i < addrs.size(); i++) chk($sformatf("%s addr%0d", tag, i), 32'(addrs[i]), 32'(i));
        if (fast) foreach (idles[i]) chk($sformatf("%s idle%0d", tag, i), 32'(idles[i]), 0);
        chk({tag, " addr back"}, 32'(TX_RAM_ADDR_OUT), 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst out", 32'(OUT), 1);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst end", 32'(TX_END_MESSAGE), 0);
        chk("rst req", 32'(TX_RAM_REQ_RD), 0);
        chk("rst addr", 32'(TX_RAM_ADDR_OUT), 0);
        RESET = 1'b1;
        run_frame(8'h3C, 0, 1, 0, 1, "n0");
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        run_frame(8'($urandom), 3, 1, 0, 1, "n3");
        run_frame(8'($urandom), 2, 120, 0, 0, "slow");
        chk("slow hold", 32'(idles.size() > 3 && idles[3] > 0), 1);
        run_frame(8'($urandom), 5, 3, 60, 1, "restart");
        ram_delay = 1;
        @(posedge CLK); #1;
        TX_FLAG = 8'h5A;
        TX_BYTE_NUMBER = 16'd4;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        cyc = 0;
        while (TX_RAM_ADDR_OUT != 16'd3 && cyc < 5000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("abort reach", 32'(cyc < 5000), 1);
        repeat (20) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        chk("abort out", 32'(OUT), 1);
        chk("abort busy", 32'(BUSY), 0);
        chk("abort req", 32'(TX_RAM_REQ_RD), 0);
        chk("abort addr", 32'(TX_RAM_ADDR_OUT), 0);
        chk("abort end", 32'(TX_END_MESSAGE), 0);
        repeat (5) @(posedge CLK);
        #1;
        RESET = 1'b1;
        run_frame(8'h5A, 4, 1, 0, 1, "post rst");
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            run_frame(8'($urandom), int'($urandom_range(0, 8)), int'($urandom_range(1, 10)),
                      int'($urandom_range(0, 200)), 1, $sformatf("rand%0d", f));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
